// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller.
//   state_t     : FSM state encoding, also exported on the state port
//   CLK_HZ      : default input clock frequency
//   TICK_HZ     : default count-tick rate (one tick per 10 ms)
//   DB_CYCLES   : default number of stable samples needed to accept a key change
//   next_state(): start/display transition rules (reset handled by the caller)
package stopwatch_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned TICK_HZ   = 100;
  localparam int unsigned DB_CYCLES = 255;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_PAUSE     = 3'd2,
    S_LAP       = 3'd3,
    S_LAP_PAUSE = 3'd4
  } state_t;

  // Start wins over display; a display event arriving with a start event is dropped.
  function automatic state_t next_state(state_t s, logic start, logic disp);
    state_t n;
    n = s;
    if (start) begin
      case (s)
        S_IDLE:      n = S_RUN;
        S_RUN:       n = S_PAUSE;
        S_PAUSE:     n = S_RUN;
        S_LAP:       n = S_LAP_PAUSE;
        S_LAP_PAUSE: n = S_LAP;
        default:     n = S_IDLE;
      endcase
    end else if (disp) begin
      case (s)
        S_IDLE:      n = S_IDLE;
        S_RUN:       n = S_LAP;
        S_LAP:       n = S_RUN;
        S_PAUSE:     n = S_LAP_PAUSE;
        S_LAP_PAUSE: n = S_PAUSE;
        default:     n = S_IDLE;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Key inputs and control outputs of the stopwatch controller.
//   key_reset, key_start_pause, key_display_stop : raw buttons, 0 = pressed
//   cnt_tick    : one-cycle pulse, advance time counters by 10 ms
//   cnt_clr     : one-cycle pulse, clear time counters
//   disp_follow : 1 = display tracks counters, 0 = display frozen
//   running     : 1 while time advances
//   state       : FSM state encoding
// master drives the keys and observes the outputs; slave is the controller.
interface stopwatch_ctrl_if;
  logic       key_reset;
  logic       key_start_pause;
  logic       key_display_stop;
  logic       cnt_tick;
  logic       cnt_clr;
  logic       disp_follow;
  logic       running;
  logic [2:0] state;

  modport master (
    output key_reset, key_start_pause, key_display_stop,
    input  cnt_tick, cnt_clr, disp_follow, running, state
  );

  modport slave (
    input  key_reset, key_start_pause, key_display_stop,
    output cnt_tick, cnt_clr, disp_follow, running, state
  );
endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, run-length debouncer and
// press-pulse generator for one active-low key.
//   clk, rst : clock and asynchronous active-high reset
//   key_i    : raw key, 0 = pressed, asynchronous to clk
//   press_o  : one-cycle pulse on the debounced 1->0 transition
module key_debounce #(
  parameter int unsigned DB_CYCLES = stopwatch_pkg::DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
        // DB_CYCLES-th consecutive differing sample: accept it. The pulse is
        // registered on the same edge so it appears with the new level.
        cnt_q   <= '0;
        level_q <= sync2_q;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM with key conditioning and 10 ms tick prescaler.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : stopwatch_ctrl_if.slave (keys in; cnt_tick, cnt_clr,
//              disp_follow, running, state out)
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ    = stopwatch_pkg::CLK_HZ,
  parameter int unsigned TICK_HZ   = stopwatch_pkg::TICK_HZ,
  parameter int unsigned DB_CYCLES = stopwatch_pkg::DB_CYCLES
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);
  import stopwatch_pkg::*;

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic press_rst;
  logic press_start;
  logic press_disp;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
    .clk(clk), .rst(rst), .key_i(bus.key_reset), .press_o(press_rst)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk(clk), .rst(rst), .key_i(bus.key_start_pause), .press_o(press_start)
  );
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_disp (
    .clk(clk), .rst(rst), .key_i(bus.key_display_stop), .press_o(press_disp)
  );

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic          tick_q;
  logic          clr_q;
  logic          run;

  assign run = (state_q == S_RUN) || (state_q == S_LAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      clr_q  <= 1'b0;
      if (press_rst) begin
        // Reset press wins over everything, including a tick due this edge.
        state_q <= S_IDLE;
        presc_q <= '0;
        clr_q   <= 1'b1;
      end else begin
        state_q <= next_state(state_q, press_start, press_disp);
        // Pause states simply hold presc_q, so resume keeps sub-tick phase.
        if (run) begin
          if (presc_q == PW'(DIV - 1)) begin
            presc_q <= '0;
            tick_q  <= 1'b1;
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.running     = run;
  assign bus.disp_follow = !((state_q == S_LAP) || (state_q == S_LAP_PAUSE));
  assign bus.cnt_tick    = tick_q;
  assign bus.cnt_clr     = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (CLK_HZ=1000, TICK_HZ=100, DB_CYCLES=4).
module tb_stopwatch_ctrl;
  localparam int DB  = 4;
  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  stopwatch_ctrl_if bus();

  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DB_CYCLES(DB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model. Keys: 0 = reset, 1 = start/pause, 2 = display.
  // A key's debounced level flips when the last DB synchronized samples
  // (raw samples delayed by two clocks) all differ from it.
  int          start_next[5] = '{1, 2, 1, 4, 3};
  int          disp_next[5]  = '{0, 3, 4, 1, 2};
  logic [63:0] hist[3];
  logic        lvl[3];
  logic        pulse[3];
  logic        pold[3];
  logic        raw[3];
  logic        all_diff;
  int          m_state  = 0;
  int          m_runcnt = 0;
  int          m_presc  = 0;
  logic        m_tick   = 1'b0;
  logic        m_clr    = 1'b0;
  int          dur[3];
  logic        v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        hist[k]  = '1;
        lvl[k]   = 1'b1;
        pulse[k] = 1'b0;
      end
      m_state = 0; m_runcnt = 0; m_presc = 0; m_tick = 1'b0; m_clr = 1'b0;
    end else begin
      pold   = pulse;
      m_tick = 1'b0;
      m_clr  = 1'b0;
      if (pold[0]) begin
        m_state  = 0;
        m_runcnt = 0;
        m_clr    = 1'b1;
      end else begin
        if (m_state == 1 || m_state == 3) begin
          m_runcnt++;
          m_tick = (m_runcnt % DIV == 0);
        end
        if (pold[1])      m_state = start_next[m_state];
        else if (pold[2]) m_state = disp_next[m_state];
      end
      m_presc = m_runcnt % DIV;
      raw[0] = bus.key_reset;
      raw[1] = bus.key_start_pause;
      raw[2] = bus.key_display_stop;
      for (int k = 0; k < 3; k++) begin
        hist[k]  = {hist[k][62:0], raw[k]};
        pulse[k] = 1'b0;
        all_diff = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (hist[k][j] == lvl[k]) all_diff = 1'b0;
        if (all_diff) begin
          pulse[k] = lvl[k];
          lvl[k]   = ~lvl[k];
        end
      end
    end
  end

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".state"},       int'(bus.state),       m_state);
    chk({tag, ".running"},     int'(bus.running),     (m_state == 1 || m_state == 3) ? 1 : 0);
    chk({tag, ".disp_follow"}, int'(bus.disp_follow), (m_state >= 3) ? 0 : 1);
    chk({tag, ".tick"},        int'(bus.cnt_tick),    int'(m_tick));
    chk({tag, ".clr"},         int'(bus.cnt_clr),     int'(m_clr));
    chk({tag, ".presc"},       int'(dut.presc_q),     m_presc);
  endtask

  task automatic step(string tag, int n);
    repeat (n) begin
      @(negedge clk);
      chk_all(tag);
    end
  endtask

  task automatic set_key(int k, logic val);
    case (k)
      0:       bus.key_reset        = val;
      1:       bus.key_start_pause  = val;
      default: bus.key_display_stop = val;
    endcase
  endtask

  task automatic press(string tag, int k);
    set_key(k, 1'b0);
    step(tag, 8);
    set_key(k, 1'b1);
    step(tag, 10);
  endtask

  initial begin
    bus.key_reset = 1'b1;
    bus.key_start_pause = 1'b1;
    bus.key_display_stop = 1'b1;

    // Reset values
    repeat (3) begin
      @(negedge clk);
      chk("rst.state", int'(bus.state), 0);
      chk("rst.running", int'(bus.running), 0);
      chk("rst.disp_follow", int'(bus.disp_follow), 1);
      chk("rst.tick", int'(bus.cnt_tick), 0);
      chk("rst.clr", int'(bus.cnt_clr), 0);
      chk("rst.presc", int'(dut.presc_q), 0);
    end
    rst = 1'b0;
    step("post_rst", 3);

    // Bounce: toggle every 2 cycles, no event
    for (int i = 0; i < 30; i++) begin
      bus.key_start_pause = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step("bounce", 1);
    end
    bus.key_start_pause = 1'b1;
    step("bounce", 10);
    chk("bounce.idle", int'(bus.state), 0);

    // Start press latency and tick period
    bus.key_start_pause = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step("lat", 1);
      if (k == 6) chk("lat.idle_c6", int'(bus.state), 0);
      if (k == 7) chk("lat.run_c7", int'(bus.state), 1);
      if (k >= 8) chk("lat.tick_period", int'(bus.cnt_tick), (k >= 17 && (k - 17) % 10 == 0) ? 1 : 0);
      if (k == 20) bus.key_start_pause = 1'b1;
    end

    // Pause holds prescaler at 7, resume ticks 3 cycles later
    for (int n = 0; n < 20 && bus.cnt_tick !== 1'b1; n++) step("wait_tick", 1);
    chk("pause.tick_seen", int'(bus.cnt_tick), 1);
    bus.key_start_pause = 1'b0;
    step("pause", 7);
    chk("pause.state", int'(bus.state), 2);
    chk("pause.presc7", int'(dut.presc_q), 7);
    bus.key_start_pause = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step("pause_hold", 1);
      chk("pause.hold7", int'(dut.presc_q), 7);
    end
    bus.key_start_pause = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step("resume", 1);
      if (k == 7) chk("resume.state", int'(bus.state), 1);
      if (k == 7) chk("resume.presc7", int'(dut.presc_q), 7);
      if (k >= 8) chk("resume.tick", int'(bus.cnt_tick), (k == 10) ? 1 : 0);
    end
    bus.key_start_pause = 1'b1;
    step("resume", 10);

    // Lap and lap-pause freeze the display
    press("lap", 2);
    chk("lap.state", int'(bus.state), 3);
    chk("lap.follow", int'(bus.disp_follow), 0);
    press("lappause", 1);
    chk("lappause.state", int'(bus.state), 4);
    chk("lappause.follow", int'(bus.disp_follow), 0);
    chk("lappause.running", int'(bus.running), 0);
    press("lap2", 1);
    chk("lap2.state", int'(bus.state), 3);

    // Reset + start together in LAP, with a tick due on the same edge
    for (int n = 0; n < 20 && m_presc != 3; n++) step("wait_p3", 1);
    chk("clr.presc3", int'(dut.presc_q), 3);
    bus.key_reset = 1'b0;
    bus.key_start_pause = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step("clr", 1);
      if (k == 7) begin
        chk("clr.state", int'(bus.state), 0);
        chk("clr.pulse", int'(bus.cnt_clr), 1);
        chk("clr.no_tick", int'(bus.cnt_tick), 0);
        chk("clr.presc0", int'(dut.presc_q), 0);
      end
      if (k == 8) chk("clr.one_cycle", int'(bus.cnt_clr), 0);
    end
    bus.key_reset = 1'b1;
    bus.key_start_pause = 1'b1;
    step("clr", 10);

    // Start overrides display; display in pause states; reset press; idle ignores display
    press("run", 1);
    bus.key_start_pause = 1'b0;
    bus.key_display_stop = 1'b0;
    step("both", 8);
    bus.key_start_pause = 1'b1;
    bus.key_display_stop = 1'b1;
    step("both", 10);
    chk("both.pause", int'(bus.state), 2);
    press("pdisp", 2);
    chk("pdisp.state", int'(bus.state), 4);
    press("lpdisp", 2);
    chk("lpdisp.state", int'(bus.state), 2);
    press("rkey", 0);
    chk("rkey.state", int'(bus.state), 0);
    press("idisp", 2);
    chk("idisp.state", int'(bus.state), 0);

    // Async rst in LAP with a key held low
    press("run3", 1);
    press("lap3", 2);
    chk("lap3.state", int'(bus.state), 3);
    bus.key_start_pause = 1'b0;
    step("hold", 3);
    #1 rst = 1'b1;
    #1;
    chk("arst.state", int'(bus.state), 0);
    chk("arst.running", int'(bus.running), 0);
    chk("arst.follow", int'(bus.disp_follow), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step("arst_rel", 1);
      if (k <= 6) chk("arst.no_event", int'(bus.state), 0);
      if (k == 7) chk("arst.run_c7", int'(bus.state), 1);
    end
    bus.key_start_pause = 1'b1;
    step("arst_rel", 10);

    // Randomized key activity against the model
    for (int k = 0; k < 3; k++) dur[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (dur[k] == 0) begin
          if (k == 0) v = ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1;
          else        v = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
          set_key(k, v);
          dur[k] = (v == 1'b0) ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 25));
        end
        dur[k]--;
      end
      step("rand", 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
